// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32IM encodings for decode, execute and writeback
package riscv_pkg;
   localparam int XLEN = 32;
   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASSB  = 4'd10,
      ALU_MUL    = 4'd11,
      ALU_MULH   = 4'd12,
      ALU_MULHSU = 4'd13,
      ALU_MULHU  = 4'd14,
      ALU_NOP    = 4'd15
   } alu_sel_e;
   typedef enum logic [2:0] {
      BR_EQ  = 3'b000,
      BR_NE  = 3'b001,
      BR_LT  = 3'b100,
      BR_GE  = 3'b101,
      BR_LTU = 3'b110,
      BR_GEU = 3'b111
   } br_type_e;
   typedef enum logic [1:0] {
      WB_MEM = 2'd0,
      WB_ALU = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;
   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;
endpackage

// File: rtl/mul_iter.sv
// mul_iter: 32-step shift-add multiplier on magnitudes with sign fix-up in DONE
module mul_iter
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   mul_state_e state, state_nx;
   logic [4:0] cnt;
   logic [2*XLEN-1:0] prod, fixed;
   logic [XLEN-1:0] mag_a;
   logic [XLEN:0] sum;
   logic neg, hi, sa, sb;

   // sign flags, one shift-add step and the signed result selection
   always_comb begin
      sa = a[XLEN-1] & (op != ALU_MULHU);
      sb = b[XLEN-1] & (op == ALU_MUL || op == ALU_MULH);
      sum = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, prod[0] ? mag_a : '0};
      fixed = neg ? -prod : prod;
      result = hi ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
      busy = state == MUL_BUSY;
      done = state == MUL_DONE;
   end

   // next state: flush always returns to IDLE
   always_comb begin
      state_nx = flush ? MUL_IDLE :
                 (state == MUL_IDLE && start) ? MUL_BUSY :
                 (state == MUL_BUSY && cnt == 5'd0) ? MUL_DONE :
                 (state == MUL_DONE) ? MUL_IDLE : state;
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= MUL_IDLE;
      else state <= state_nx;
   end

   // operand latch on accept, then one product step per BUSY cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         prod <= '0;
         mag_a <= '0;
         neg <= 1'b0;
         hi <= 1'b0;
      end else if (state == MUL_IDLE && start && !flush) begin
         cnt <= 5'd31;
         mag_a <= sa ? -a : a;
         prod <= {{XLEN{1'b0}}, sb ? -b : b};
         neg <= sa ^ sb;
         hi <= op != ALU_MUL;
      end else if (state == MUL_BUSY) begin
         cnt <= cnt - 5'd1;
         prod <= {sum, prod[XLEN-1:1]};
      end
   end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: forwarding, ALU, branch resolution, multiplier and EX/MEM register
module ex_stage
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_we,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_DataA,
   input  logic [XLEN-1:0] ex_DataB,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [4:0]      ex_rs1,
   input  logic [4:0]      ex_rs2,
   input  logic [4:0]      ex_rd,
   input  logic            ex_ASel,
   input  logic            ex_BSel,
   input  logic [3:0]      ex_ALUSel,
   input  logic [2:0]      ex_BrType,
   input  logic            ex_Branch,
   input  logic            ex_Jump,
   input  logic            ex_BrUn,
   input  logic            ex_MemRW,
   input  logic            ex_RegWEn,
   input  logic [1:0]      ex_WBSel,
   input  logic            ex_flush,
   input  logic [4:0]      mem_fwd_rd,
   input  logic [4:0]      wb_fwd_rd,
   input  logic            mem_fwd_en,
   input  logic            wb_fwd_en,
   input  logic [XLEN-1:0] mem_fwd_data,
   input  logic [XLEN-1:0] wb_fwd_data,
   output logic            ex_stall,
   output logic            ex_PCSel,
   output logic [XLEN-1:0] ex_target,
   output logic            mem_we,
   output logic            mem_RegWEn,
   output logic            mem_MemRW,
   output logic [1:0]      mem_WBSel,
   output logic [4:0]      mem_rd,
   output logic [XLEN-1:0] mem_alu,
   output logic [XLEN-1:0] mem_DataB,
   output logic [XLEN-1:0] mem_pc4
);
   logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu, mul_res;
   logic is_mul, mul_start, mul_busy, mul_done, br_eq, br_lt, taken, fire;

   // operand forwarding, MEM over WB, x0 never forwarded
   always_comb begin
      fwd_a = (mem_fwd_en && mem_fwd_rd != 5'd0 && mem_fwd_rd == ex_rs1) ? mem_fwd_data :
              (wb_fwd_en && wb_fwd_rd != 5'd0 && wb_fwd_rd == ex_rs1) ? wb_fwd_data : ex_DataA;
      fwd_b = (mem_fwd_en && mem_fwd_rd != 5'd0 && mem_fwd_rd == ex_rs2) ? mem_fwd_data :
              (wb_fwd_en && wb_fwd_rd != 5'd0 && wb_fwd_rd == ex_rs2) ? wb_fwd_data : ex_DataB;
      op_a = ex_ASel ? ex_pc : fwd_a;
      op_b = ex_BSel ? ex_imm : fwd_b;
   end

   // single-cycle ALU; multiply codes return the multiplier result
   always_comb begin
      case (ex_ALUSel)
         ALU_ADD:   alu = op_a + op_b;
         ALU_SUB:   alu = op_a - op_b;
         ALU_SLL:   alu = op_a << op_b[4:0];
         ALU_SLT:   alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_SLTU:  alu = {{(XLEN-1){1'b0}}, op_a < op_b};
         ALU_XOR:   alu = op_a ^ op_b;
         ALU_SRL:   alu = op_a >> op_b[4:0];
         ALU_SRA:   alu = $unsigned($signed(op_a) >>> op_b[4:0]);
         ALU_OR:    alu = op_a | op_b;
         ALU_AND:   alu = op_a & op_b;
         ALU_PASSB: alu = op_b;
         ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: alu = mul_res;
         default:   alu = '0;
      endcase
   end

   // branch compare, stall and redirect
   always_comb begin
      br_eq = fwd_a == fwd_b;
      br_lt = ex_BrUn ? fwd_a < fwd_b : $signed(fwd_a) < $signed(fwd_b);
      case (ex_BrType)
         BR_EQ:          taken = br_eq;
         BR_NE:          taken = !br_eq;
         BR_LT, BR_LTU:  taken = br_lt;
         BR_GE, BR_GEU:  taken = !br_lt;
         default:        taken = 1'b0;
      endcase
      is_mul = ex_ALUSel inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
      mul_start = ex_we & is_mul & !mul_busy & !mul_done;
      ex_stall = !ex_flush & (mul_start | (ex_we & is_mul & mul_busy));
      fire = ex_we & !ex_flush & !ex_stall;
      ex_PCSel = fire & (ex_Jump | (ex_Branch & taken));
      ex_target = {alu[XLEN-1:1], 1'b0};
   end

   mul_iter u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_start),
      .flush  (ex_flush),
      .op     (ex_ALUSel),
      .a      (op_a),
      .b      (op_b),
      .busy   (mul_busy),
      .done   (mul_done),
      .result (mul_res)
   );

   // EX/MEM register: capture on fire, otherwise bubble with data held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we <= 1'b0;
         mem_RegWEn <= 1'b0;
         mem_MemRW <= 1'b0;
         mem_WBSel <= '0;
         mem_rd <= '0;
         mem_alu <= '0;
         mem_DataB <= '0;
         mem_pc4 <= '0;
      end else if (fire) begin
         mem_we <= 1'b1;
         mem_RegWEn <= ex_RegWEn;
         mem_MemRW <= ex_MemRW;
         mem_WBSel <= ex_WBSel;
         mem_rd <= ex_rd;
         mem_alu <= alu;
         mem_DataB <= fwd_b;
         mem_pc4 <= ex_pc + 32'd4;
      end else begin
         mem_we <= 1'b0;
         mem_RegWEn <= 1'b0;
         mem_MemRW <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard-driven bench for the execute stage
module tb_ex_stage;
   logic clk = 1'b0, rst = 1'b1;
   logic ex_we, ex_ASel, ex_BSel, ex_Branch, ex_Jump, ex_BrUn, ex_MemRW, ex_RegWEn, ex_flush;
   logic [31:0] ex_pc, ex_DataA, ex_DataB, ex_imm, mem_fwd_data, wb_fwd_data;
   logic [4:0] ex_rs1, ex_rs2, ex_rd, mem_fwd_rd, wb_fwd_rd;
   logic [3:0] ex_ALUSel;
   logic [2:0] ex_BrType;
   logic [1:0] ex_WBSel;
   logic mem_fwd_en, wb_fwd_en;
   logic ex_stall, ex_PCSel, mem_we, mem_RegWEn, mem_MemRW;
   logic [31:0] ex_target, mem_alu, mem_DataB, mem_pc4;
   logic [1:0] mem_WBSel;
   logic [4:0] mem_rd;

   typedef struct {
      logic [31:0] alu;
      string name;
   } exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;

   ex_stage dut (
      .clk(clk), .rst(rst), .ex_we(ex_we), .ex_pc(ex_pc), .ex_DataA(ex_DataA),
      .ex_DataB(ex_DataB), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_ASel(ex_ASel), .ex_BSel(ex_BSel), .ex_ALUSel(ex_ALUSel), .ex_BrType(ex_BrType),
      .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_BrUn(ex_BrUn), .ex_MemRW(ex_MemRW),
      .ex_RegWEn(ex_RegWEn), .ex_WBSel(ex_WBSel), .ex_flush(ex_flush),
      .mem_fwd_rd(mem_fwd_rd), .wb_fwd_rd(wb_fwd_rd), .mem_fwd_en(mem_fwd_en),
      .wb_fwd_en(wb_fwd_en), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
      .ex_stall(ex_stall), .ex_PCSel(ex_PCSel), .ex_target(ex_target), .mem_we(mem_we),
      .mem_RegWEn(mem_RegWEn), .mem_MemRW(mem_MemRW), .mem_WBSel(mem_WBSel), .mem_rd(mem_rd),
      .mem_alu(mem_alu), .mem_DataB(mem_DataB), .mem_pc4(mem_pc4)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mul_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      p = (op == 4'd12) ? sa * sb : (op == 4'd13) ? sa * ub : ua * ub;
      return (op == 4'd11) ? p[31:0] : p[63:32];
   endfunction

   task automatic drive(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r1, input logic [4:0] r2);
      ex_we = 1'b1; ex_ALUSel = sel; ex_DataA = a; ex_DataB = b; ex_rs1 = r1; ex_rs2 = r2;
      ex_ASel = 1'b0; ex_BSel = 1'b0; ex_Branch = 1'b0; ex_Jump = 1'b0; ex_BrType = 3'd0;
      ex_BrUn = 1'b0; ex_flush = 1'b0; mem_fwd_en = 1'b0; wb_fwd_en = 1'b0;
      mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0; mem_fwd_data = 32'd0; wb_fwd_data = 32'd0;
      ex_rd = 5'd10; ex_RegWEn = 1'b1; ex_WBSel = 2'd1; ex_MemRW = 1'b0;
      ex_pc = 32'h40; ex_imm = 32'd0;
   endtask

   task automatic test_reset();
      drive(4'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      ex_we = 1'b0;
      #12;
      checks++;
      if ({mem_we, mem_RegWEn, mem_MemRW, mem_WBSel, mem_rd, mem_alu, mem_DataB, mem_pc4} !== '0) begin
         errors++; $display("FAIL reset_mem: we=%b alu=%h pc4=%h expected all zero", mem_we, mem_alu, mem_pc4);
      end
      checks++;
      if (ex_stall !== 1'b0 || ex_PCSel !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: stall=%b pcsel=%b expected 0 0", ex_stall, ex_PCSel);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   typedef struct {
      logic [4:0] r1, r2, mrd, wrd;
      logic men, wen;
      logic [31:0] mdata, wdata, alu, datab;
   } fwd_row_t;

   task automatic test_forward();
      fwd_row_t t[4];
      exp_t e;
      t = '{'{5'd5, 5'd6, 5'd5, 5'd6, 1'b1, 1'b1, 32'd100, 32'd7, 32'd107, 32'd7},
            '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'd100, 32'd100, 32'd3, 32'd2},
            '{5'd5, 5'd7, 5'd5, 5'd5, 1'b1, 1'b1, 32'd100, 32'd200, 32'd102, 32'd2},
            '{5'd5, 5'd6, 5'd5, 5'd6, 1'b0, 1'b0, 32'd100, 32'd7, 32'd3, 32'd2}};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(4'd0, 32'd1, 32'd2, t[i].r1, t[i].r2);
         mem_fwd_rd = t[i].mrd; mem_fwd_en = t[i].men; mem_fwd_data = t[i].mdata;
         wb_fwd_rd = t[i].wrd; wb_fwd_en = t[i].wen; wb_fwd_data = t[i].wdata;
         q.push_back('{t[i].alu, $sformatf("fwd%0d", i)});
         @(posedge clk); #1;
         e = q.pop_front();
         checks++;
         if (mem_we !== 1'b1 || mem_alu !== e.alu || mem_rd !== 5'd10 || mem_RegWEn !== 1'b1) begin
            errors++; $display("FAIL %s: we=%b alu=%h rd=%0d expected we=1 alu=%h rd=10", e.name, mem_we, mem_alu, mem_rd, e.alu);
         end
         checks++;
         if (mem_DataB !== t[i].datab) begin
            errors++; $display("FAIL %s_datab: got %h expected %h", e.name, mem_DataB, t[i].datab);
         end
      end
   endtask

   typedef struct {
      logic [3:0] sel;
      logic [31:0] a, b, r;
   } alu_row_t;

   task automatic test_alu();
      alu_row_t t[11];
      exp_t e;
      t = '{'{4'd1, 32'd5, 32'd7, 32'hFFFFFFFE},
            '{4'd2, 32'd1, 32'd33, 32'd2},
            '{4'd3, 32'hFFFFFFFF, 32'd1, 32'd1},
            '{4'd4, 32'hFFFFFFFF, 32'd1, 32'd0},
            '{4'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0},
            '{4'd6, 32'h80000000, 32'd4, 32'h08000000},
            '{4'd7, 32'h80000000, 32'd4, 32'hF8000000},
            '{4'd8, 32'h0000F000, 32'h0000000F, 32'h0000F00F},
            '{4'd9, 32'h0000FFFF, 32'h00FF00FF, 32'h000000FF},
            '{4'd10, 32'h12345678, 32'hCAFEBABE, 32'hCAFEBABE},
            '{4'd15, 32'h12345678, 32'hCAFEBABE, 32'd0}};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         drive(t[i].sel, t[i].a, t[i].b, 5'd1, 5'd2);
         q.push_back('{t[i].r, $sformatf("alu_sel%0d", t[i].sel)});
         @(posedge clk); #1;
         e = q.pop_front();
         checks++;
         if (mem_we !== 1'b1 || mem_alu !== e.alu) begin
            errors++; $display("FAIL %s: we=%b alu=%h expected we=1 alu=%h", e.name, mem_we, mem_alu, e.alu);
         end
      end
   endtask

   typedef struct {
      logic [31:0] a, b, pc, imm;
      logic brun, branch, jump, pcsel;
      logic [2:0] brtype;
   } br_row_t;

   task automatic test_branch();
      br_row_t t[6];
      exp_t e;
      logic [31:0] sum;
      t = '{'{32'h55, 32'h55, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000},
            '{32'h55, 32'h55, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001},
            '{32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 3'b110},
            '{32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0, 1'b1, 3'b100},
            '{32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 1'b1, 1'b1, 1'b0, 1'b1, 3'b111},
            '{32'd0, 32'd0, 32'h200, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000}};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(4'd0, t[i].a, t[i].b, 5'd1, 5'd2);
         ex_ASel = 1'b1; ex_BSel = 1'b1; ex_pc = t[i].pc; ex_imm = t[i].imm;
         ex_BrUn = t[i].brun; ex_Branch = t[i].branch; ex_Jump = t[i].jump; ex_BrType = t[i].brtype;
         sum = t[i].pc + t[i].imm;
         q.push_back('{sum, $sformatf("br%0d", i)});
         #1;
         checks++;
         if (ex_PCSel !== t[i].pcsel || ex_target !== (sum & 32'hFFFFFFFE)) begin
            errors++; $display("FAIL br%0d_redirect: pcsel=%b target=%h expected %b %h", i, ex_PCSel, ex_target, t[i].pcsel, sum & 32'hFFFFFFFE);
         end
         @(posedge clk); #1;
         e = q.pop_front();
         checks++;
         if (mem_we !== 1'b1 || mem_alu !== e.alu || mem_pc4 !== t[i].pc + 32'd4) begin
            errors++; $display("FAIL %s: we=%b alu=%h pc4=%h expected 1 %h %h", e.name, mem_we, mem_alu, mem_pc4, e.alu, t[i].pc + 32'd4);
         end
      end
   endtask

   task automatic test_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
      int n = 0, bub = 0;
      exp_t e;
      @(negedge clk);
      drive(op, a, b, 5'd1, 5'd2);
      q.push_back('{mul_model(op, a, b), name});
      #1;
      while (ex_stall && n < 40) begin
         n++;
         @(posedge clk); #1;
         if (mem_we !== 1'b0 || mem_RegWEn !== 1'b0) bub++;
      end
      checks++;
      if (n != 33) begin
         errors++; $display("FAIL %s_stall: stall cycles %0d expected 33", name, n);
      end
      checks++;
      if (bub != 0) begin
         errors++; $display("FAIL %s_bubble: %0d non-bubble writes during stall expected 0", name, bub);
      end
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (mem_we !== 1'b1 || mem_alu !== e.alu) begin
         errors++; $display("FAIL %s: we=%b alu=%h expected we=1 alu=%h", e.name, mem_we, mem_alu, e.alu);
      end
      @(negedge clk); ex_we = 1'b0;
   endtask

   task automatic test_flush();
      exp_t e;
      @(negedge clk);
      drive(4'd11, 32'd5, 32'd5, 5'd1, 5'd2);
      repeat (10) @(posedge clk);
      @(negedge clk); ex_flush = 1'b1;
      #1;
      checks++;
      if (ex_stall !== 1'b0 || ex_PCSel !== 1'b0) begin
         errors++; $display("FAIL flush_stall: stall=%b pcsel=%b expected 0 0", ex_stall, ex_PCSel);
      end
      @(posedge clk); #1;
      checks++;
      if (mem_we !== 1'b0 || mem_RegWEn !== 1'b0) begin
         errors++; $display("FAIL flush_nowrite: we=%b regwen=%b expected 0 0", mem_we, mem_RegWEn);
      end
      @(negedge clk);
      drive(4'd0, 32'd3, 32'd4, 5'd1, 5'd2);
      q.push_back('{32'd7, "add_after_flush"});
      #1;
      checks++;
      if (ex_stall !== 1'b0) begin
         errors++; $display("FAIL add_after_flush_stall: stall=%b expected 0", ex_stall);
      end
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (mem_we !== 1'b1 || mem_alu !== e.alu) begin
         errors++; $display("FAIL %s: we=%b alu=%h expected we=1 alu=%h", e.name, mem_we, mem_alu, e.alu);
      end
      test_mul(4'd11, 32'd2, 32'd3, "mul_after_flush");
   endtask

   task automatic test_rst_mid();
      @(negedge clk);
      drive(4'd11, 32'd9, 32'd9, 5'd1, 5'd2);
      repeat (6) @(posedge clk);
      #3; rst = 1'b1; ex_we = 1'b0;
      #1;
      checks++;
      if ({mem_we, mem_RegWEn, mem_MemRW, mem_WBSel, mem_rd, mem_alu, mem_DataB, mem_pc4} !== '0) begin
         errors++; $display("FAIL rst_mid_mem: we=%b alu=%h databus=%h pc4=%h expected all zero", mem_we, mem_alu, mem_DataB, mem_pc4);
      end
      checks++;
      if (ex_stall !== 1'b0) begin
         errors++; $display("FAIL rst_mid_stall: stall=%b expected 0", ex_stall);
      end
      @(negedge clk); rst = 1'b0;
      test_mul(4'd11, 32'd6, 32'd7, "mul_after_rst");
   endtask

   initial begin
      test_reset();
      test_forward();
      test_alu();
      test_branch();
      test_mul(4'd11, 32'hFFFFFFFD, 32'd7, "mul");
      test_mul(4'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu");
      test_mul(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulh");
      test_mul(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
      test_flush();
      test_rst_mid();
      checks++;
      if (q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: %0d entries left expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
